// File: rtl/mu0_control.sv
// MU0 control unit: three-state FETCH/EXECUTE/HALT sequencer.
// It decodes the opcode and the accumulator flags into datapath selects, enables and memory strobes.
module mu0_control (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    output logic       X_sel,
    output logic       Y_sel,
    output logic       Addr_sel,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Acc_En,
    output logic [1:0] ALU_FS,
    output logic       MEM_rd,
    output logic       MEM_wr,
    output logic       Halted
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [1:0] FS_PASSY = 2'b00;
    localparam logic [1:0] FS_ADD   = 2'b01;
    localparam logic [1:0] FS_INC   = 2'b10;
    localparam logic [1:0] FS_SUB   = 2'b11;

    logic [1:0] r_state;
    logic [1:0] w_next;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        X_sel    = 1'b0;
        Y_sel    = 1'b0;
        Addr_sel = 1'b0;
        PC_En    = 1'b0;
        IR_En    = 1'b0;
        Acc_En   = 1'b0;
        ALU_FS   = FS_PASSY;
        MEM_rd   = 1'b0;
        MEM_wr   = 1'b0;
        Halted   = 1'b0;
        w_next   = S_FETCH;
        case (r_state)
            S_FETCH: begin
                // IR <= mem[PC] and PC <= PC+1 share the same edge
                MEM_rd = 1'b1;
                IR_En  = 1'b1;
                X_sel  = 1'b1;
                ALU_FS = FS_INC;
                PC_En  = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = (F == 4'h7) ? S_HALT : S_FETCH;
                case (F)
                    4'h0: begin
                        Addr_sel = 1'b1;
                        MEM_rd   = 1'b1;
                        Acc_En   = 1'b1;
                    end
                    4'h1: begin
                        Addr_sel = 1'b1;
                        MEM_wr   = 1'b1;
                    end
                    4'h2, 4'h3: begin
                        Addr_sel = 1'b1;
                        MEM_rd   = 1'b1;
                        Acc_En   = 1'b1;
                        ALU_FS   = (F == 4'h2) ? FS_ADD : FS_SUB;
                    end
                    4'h4, 4'h5, 4'h6: begin
                        // jump target is IR[11:0] passed straight through the ALU
                        Y_sel = 1'b1;
                        PC_En = (F == 4'h4) ? 1'b1 : (F == 4'h5) ? ~N : ~Z;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                Halted = 1'b1;
                w_next = S_HALT;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mu0_control.sv
// Directed table-driven bench for mu0_control plus hand sequences for reset/halt corners.
module tb_mu0_control;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] F = 4'h0;
    logic       N = 1'b0;
    logic       Z = 1'b0;
    logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, MEM_rd, MEM_wr, Halted;
    logic [1:0] ALU_FS;

    int checks = 0;
    int failures = 0;

    mu0_control dut (
        .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z),
        .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .PC_En(PC_En),
        .IR_En(IR_En), .Acc_En(Acc_En), .ALU_FS(ALU_FS), .MEM_rd(MEM_rd),
        .MEM_wr(MEM_wr), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    // {X_sel,Y_sel,Addr_sel,PC_En,IR_En,Acc_En,ALU_FS,MEM_rd,MEM_wr,Halted}
    logic [10:0] w_out;
    assign w_out = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, ALU_FS, MEM_rd, MEM_wr, Halted};

    localparam logic [10:0] O_FETCH = 11'b1_0_0_1_1_0_10_1_0_0;
    localparam logic [10:0] O_HALT  = 11'b0_0_0_0_0_0_00_0_0_1;
    localparam logic [10:0] O_IDLE  = 11'b0_0_0_0_0_0_00_0_0_0;

    typedef struct {
        logic [3:0]  f;
        logic        n;
        logic        z;
        logic [10:0] exp_exec;
        logic        halts;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // assert reset away from the clock edge, check reset outputs, then release
    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("reset_outputs", w_out, O_FETCH);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'h0, 1'b0, 1'b0, 11'b0_0_1_0_0_1_00_1_0_0, 1'b0, "LDA"};
        vecs[1]  = '{4'h1, 1'b0, 1'b0, 11'b0_0_1_0_0_0_00_0_1_0, 1'b0, "STA"};
        vecs[2]  = '{4'h2, 1'b1, 1'b0, 11'b0_0_1_0_0_1_01_1_0_0, 1'b0, "ADD"};
        vecs[3]  = '{4'h3, 1'b0, 1'b1, 11'b0_0_1_0_0_1_11_1_0_0, 1'b0, "SUB"};
        vecs[4]  = '{4'h4, 1'b1, 1'b1, 11'b0_1_0_1_0_0_00_0_0_0, 1'b0, "JMP"};
        vecs[5]  = '{4'h5, 1'b1, 1'b0, 11'b0_1_0_0_0_0_00_0_0_0, 1'b0, "JGE_neg"};
        vecs[6]  = '{4'h5, 1'b0, 1'b1, 11'b0_1_0_1_0_0_00_0_0_0, 1'b0, "JGE_pos"};
        vecs[7]  = '{4'h6, 1'b0, 1'b1, 11'b0_1_0_0_0_0_00_0_0_0, 1'b0, "JNE_zero"};
        vecs[8]  = '{4'h6, 1'b1, 1'b0, 11'b0_1_0_1_0_0_00_0_0_0, 1'b0, "JNE_nz"};
        vecs[9]  = '{4'hA, 1'b0, 1'b0, O_IDLE,                     1'b0, "NOP_A"};
        vecs[10] = '{4'hF, 1'b1, 1'b1, O_IDLE,                     1'b0, "NOP_F"};
        vecs[11] = '{4'h7, 1'b0, 1'b0, O_IDLE,                     1'b1, "STP"};

        // table: fetch, execute, then the state that follows
        foreach (vecs[i]) begin
            do_reset();
            F = vecs[i].f; N = vecs[i].n; Z = vecs[i].z;
            #1;
            check({vecs[i].name, "_fetch"}, w_out, O_FETCH);
            tick();
            check({vecs[i].name, "_exec"}, w_out, vecs[i].exp_exec);
            tick();
            check({vecs[i].name, "_next"}, w_out, vecs[i].halts ? O_HALT : O_FETCH);
        end

        // LDA stream: F,E,F,E with Acc_En only in E, MEM_rd always
        do_reset();
        F = 4'h0; N = 1'b0; Z = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("lda_stream_c%0d", c), w_out,
                  (c % 2 == 0) ? O_FETCH : 11'b0_0_1_0_0_1_00_1_0_0);
            tick();
        end

        // halt holds for 10 clocks whatever F/N/Z do
        do_reset();
        F = 4'h7;
        tick();
        tick();
        for (int c = 0; c < 10; c++) begin
            F = 4'($urandom_range(0, 15)); N = 1'($urandom); Z = 1'($urandom);
            #1;
            check($sformatf("halt_hold_c%0d", c), w_out, O_HALT);
            tick();
        end

        // reset between edges while halted: FETCH outputs before the next clock
        #2;
        Reset = 1'b1;
        #1;
        check("halt_async_reset", w_out, O_FETCH);
        #1;
        Reset = 1'b0;
        F = 4'h0;
        tick();
        check("after_halt_reset_exec", w_out, 11'b0_0_1_0_0_1_00_1_0_0);

        // reset mid-EXECUTE aborts; first edge after release goes to EXECUTE
        F = 4'h1;
        #2;
        check("mid_exec_pre", w_out, 11'b0_0_1_0_0_0_00_0_1_0);
        Reset = 1'b1;
        #1;
        check("mid_exec_reset", w_out, O_FETCH);
        Reset = 1'b0;
        #1;
        check("mid_exec_released", w_out, O_FETCH);
        tick();
        check("mid_exec_refetch", w_out, 11'b0_0_1_0_0_0_00_0_1_0);

        // exhaustive F x N x Z in EXECUTE: strobes exclusive, no X/Z
        for (int k = 0; k < 64; k++) begin
            do_reset();
            tick();
            F = 4'(k >> 2); N = k[1]; Z = k[0];
            #1;
            check($sformatf("sweep_excl_%0d", k), {10'd0, (MEM_rd & MEM_wr) | ^w_out === 1'bx}, 11'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mu0_control.md
MU0_CONTROL -- requirements
Module: MU0_Control

Interface
REQ-001 SHALL have no parameters; widths fixed by MU0 ISA (16-bit word, 4-bit opcode).
REQ-002 SHALL have ports, one per line:
  Clk       input   1   system clock, rising-edge active
  Reset     input   1   asynchronous, active-high; forces FETCH
  F         input   4   opcode, IR[15:12]
  N         input   1   accumulator negative flag (Acc[15])
  Z         input   1   accumulator zero flag (Acc==0)
  X_sel     output  1   ALU X-mux select: 0=Acc, 1=PC
  Y_sel     output  1   ALU Y-mux select: 0=memory data, 1=IR[11:0] zero-extended
  Addr_sel  output  1   address-mux select: 0=PC, 1=IR[11:0]
  PC_En     output  1   PC load enable
  IR_En     output  1   IR load enable
  Acc_En    output  1   accumulator load enable
  ALU_FS    output  2   ALU function: 00=pass Y, 01=X+Y, 10=X+1, 11=X-Y
  MEM_rd    output  1   memory read strobe
  MEM_wr    output  1   memory write strobe
  Halted    output  1   processor stopped
REQ-003 SHALL use one clock, Clk; Reset SHALL be asynchronous and active-high.

Function
REQ-004 SHALL implement a 3-state FSM: FETCH, EXECUTE, HALT; state register updates on rising Clk only.
REQ-005 Transitions: FETCH->EXECUTE always; EXECUTE->HALT when F==4'h7; EXECUTE->FETCH otherwise; HALT->HALT until Reset.
REQ-006 Outputs SHALL be combinational from state and F, N, Z; every output not listed for a state/opcode SHALL be 0.
REQ-007 FETCH: Addr_sel=0, MEM_rd=1, IR_En=1, X_sel=1, ALU_FS=10, PC_En=1 (IR<=mem[PC], PC<=PC+1 on the same edge).
REQ-008 EXECUTE F=0 LDA: Addr_sel=1, MEM_rd=1, Y_sel=0, ALU_FS=00, Acc_En=1.
REQ-009 EXECUTE F=1 STA: Addr_sel=1, MEM_wr=1; MEM_rd=0.
REQ-010 EXECUTE F=2 ADD: Addr_sel=1, MEM_rd=1, X_sel=0, Y_sel=0, ALU_FS=01, Acc_En=1.
REQ-011 EXECUTE F=3 SUB: as ADD but ALU_FS=11.
REQ-012 EXECUTE F=4 JMP: Y_sel=1, ALU_FS=00, PC_En=1.
REQ-013 EXECUTE F=5 JGE: as JMP but PC_En=~N.
REQ-014 EXECUTE F=6 JNE: as JMP but PC_En=~Z.
REQ-015 EXECUTE F=7 STP: all enables and strobes 0; Halted rises from the following edge (HALT state).
REQ-016 EXECUTE F=8..F: no-op; all enables and strobes 0; return to FETCH.
REQ-017 HALT: Halted=1; all enables and strobes 0; F, N, Z ignored.
REQ-018 MEM_rd and MEM_wr SHALL never both be 1 in any cycle.
REQ-019 Every instruction SHALL take exactly 2 cycles (FETCH+EXECUTE); STP takes 2 cycles then holds.
REQ-020 N and Z SHALL be sampled combinationally in EXECUTE (no internal flag register).

Reset
REQ-021 Reset=1 SHALL force FETCH asynchronously, without waiting for Clk.
REQ-022 Output values under reset SHALL be the FETCH values: Addr_sel=0, MEM_rd=1, IR_En=1, PC_En=1, X_sel=1, ALU_FS=10; all others 0, Halted=0.
REQ-023 Reset asserted mid-EXECUTE or in HALT SHALL abort immediately; first edge after deassertion performs FETCH->EXECUTE.
REQ-024 No X/Z on any output after reset, for any F, N, Z.

Verification
REQ-025 Reset then 4 clocks with F=0 -> states F,E,F,E; Acc_En=1 only in E cycles; MEM_rd=1 every cycle; Halted=0.
REQ-026 F=5, N=1 in EXECUTE -> PC_En=0; same with N=0 -> PC_En=1, Y_sel=1, ALU_FS=00.
REQ-027 F=6, Z=1 -> PC_En=0; Z=0 -> PC_En=1.
REQ-028 F=1 in EXECUTE -> MEM_wr=1, MEM_rd=0, Addr_sel=1, Acc_En=0.
REQ-029 F=7 -> after EXECUTE edge Halted=1, all enables 0 for 10 clocks regardless of F/N/Z; assert Reset between edges -> Halted=0 and FETCH outputs before next Clk.
REQ-030 F=4'hA -> EXECUTE all enables/strobes 0, next state FETCH; exhaustive F x N x Z sweep -> MEM_rd&MEM_wr never 1.
